seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Output-side board I/O: drives a multiplexed common-anode 7-segment display from a CPU-written
//  hex value. Time-multiplexes DIGITS digits with per-digit dead time (ghosting suppression),
//  optional leading-zero blanking and tear-free frame-boundary updates.
//  Sits between the datapath/debug register and the board display pins.
// PARAMETERS
//  DIGITS         4   number of digits, 1..8
//  SCAN_N         11  digit slot length = 2^SCAN_N clk cycles
//  BLANK_CYC      16  dead-time cycles at start of each slot, 1..2^SCAN_N-1
//  SEG_ACT_LOW    1   1: seg_out/dp_out low = lit
//  AN_ACT_LOW     1   1: an_out low = digit selected
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  reset      in   1          synchronous, active-high
//  enable     in   1          1: scan; 0: display dark
//  load       in   1          1-cycle strobe: capture value/dp_in into pending regs
//  value      in   4*DIGITS   hex nibbles; nibble 0 = rightmost digit
//  dp_in      in   DIGITS     decimal point per digit
//  blank_lz   in   1          1: suppress leading zeros (digit 0 always shown)
//  an_out     out  DIGITS     digit select, one-hot (polarity per AN_ACT_LOW)
//  seg_out    out  7          {g,f,e,d,c,b,a} (polarity per SEG_ACT_LOW)
//  dp_out     out  1          decimal point of current digit
//  frame_tick out  1          1-cycle pulse at start of each frame (digit 0 slot)
// BEHAVIOUR
//  - Reset: state IDLE, slot counter 0, digit index 0, pending and display regs 0;
//    an_out, seg_out, dp_out all inactive level; frame_tick 0. Reset overrides everything.
//  - FSM: IDLE -> BLANK -> SHOW -> BLANK ... ; any state -> IDLE when enable=0 (next cycle).
//    IDLE: outputs inactive, counter/index held at 0. IDLE->BLANK when enable=1.
//    BLANK: cycles 0..BLANK_CYC-1 of slot; anodes inactive, segs inactive.
//    SHOW: cycles BLANK_CYC..2^SCAN_N-1; anode of current index active, seg/dp driven.
//    Slot end: counter wraps to 0, index increments; index DIGITS-1 wraps to 0.
//  - Frame start = cycle entering BLANK with index 0 (incl. first after IDLE): display regs
//    <= pending regs, frame_tick=1 that cycle only. Pending never shown mid-frame.
//  - load: pending <= {value,dp_in} on the clk edge with load=1. load coinciding with frame
//    start: new value goes straight to display regs (load wins). Load while IDLE only updates
//    pending; shown at next frame start.
//  - Outputs registered: an/seg/dp change one cycle after state/counter transitions; no
//    combinational path from inputs to outputs.
//  - Hex decode (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//    8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Polarity inverted when *_ACT_LOW=1.
//  - Leading-zero blank (blank_lz=1): digit i>0 dark (segs and dp inactive, anode still
//    driven) when nibbles DIGITS-1..i of display regs are all 0. blank_lz sampled live.
//  - enable dropped mid-slot: next cycle IDLE, outputs inactive; re-enable restarts at
//    digit 0 BLANK (new frame). Frame period = DIGITS*2^SCAN_N cycles exactly.
// TESTING  (DIGITS=4, SCAN_N=4, BLANK_CYC=2, both ACT_LOW=1)
//  - reset=1 held, enable=1 -> an_out=4'hF, seg_out=7'h7F, dp_out=1, frame_tick=0 throughout.
//  - load value=16'h12AF, enable=1 -> frame_tick every 64 cycles; each digit 2 dark + 14 lit
//    cycles; digit0 seg=~7'h71 an=4'hE, digit3 seg=~7'h06 an=4'h7.
//  - load 16'h0000 then 16'h1234 at mid-frame -> remaining digits still show 0000 pattern;
//    1234 appears from the next frame_tick onward.
//  - blank_lz=1, value=16'h0050 -> digits 3,2 dark (seg=7'h7F), digit1 '5', digit0 '0'.
//    value=0 -> only digit0 shows '0'.
//  - enable 1->0 during digit2 SHOW -> next cycle all outputs inactive; enable 0->1 ->
//    frame_tick, 2 blank cycles, then digit0 lit.
//  - load asserted on frame-start cycle with 16'hBEEF -> same frame shows BEEF on all digits.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver: per-digit dead time, optional
// leading-zero blanking and frame-aligned (tear-free) display updates.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int SCAN_N      = 11,
  parameter int BLANK_CYC   = 16,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an_out,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic                  frame_tick
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACT_LOW  ? '1 : '0;
  localparam logic [6:0]        SEG_OFF = SEG_ACT_LOW ? '1 : '0;
  localparam logic              DP_OFF  = SEG_ACT_LOW;

  localparam logic [SCAN_N-1:0] CNT_MAX    = '1;
  localparam logic [SCAN_N-1:0] BLANK_LAST = SCAN_N'(BLANK_CYC - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);

  logic [1:0]            state;
  logic [SCAN_N-1:0]     cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pend_val, disp_val;
  logic [DIGITS-1:0]     pend_dp, disp_dp;

  logic                  show;
  logic                  lz_dark;
  logic [DIGITS-1:0]     an_hi;
  logic [6:0]            seg_hi;
  logic                  dp_hi;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Output image for the current state; gated by live enable so a drop goes dark next cycle.
  always_comb begin
    show    = enable && (state == SHOW);
    lz_dark = blank_lz && (idx != '0) && ((disp_val >> (4 * idx)) == '0);
    an_hi   = '0;
    seg_hi  = '0;
    dp_hi   = 1'b0;
    if (show) begin
      an_hi = DIGITS'(1) << idx;
      if (!lz_dark) begin
        seg_hi = hex7(disp_val[4*idx +: 4]);
        dp_hi  = disp_dp[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      frame_tick <= 1'b0;
      an_out     <= AN_OFF;
      seg_out    <= SEG_OFF;
      dp_out     <= DP_OFF;
    end else begin
      frame_tick <= 1'b0;
      an_out     <= an_hi ^ AN_OFF;
      seg_out    <= seg_hi ^ SEG_OFF;
      dp_out     <= dp_hi ^ DP_OFF;

      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end

      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            frame_tick <= 1'b1;
            disp_val   <= load ? value : pend_val;
            disp_dp    <= load ? dp_in : pend_dp;
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_LAST) state <= SHOW;
          end
          SHOW: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX) begin
              state <= BLANK;
              if (idx == IDX_LAST) begin
                // Wrapping to digit 0 is a frame start: latch pending, load wins.
                idx        <= '0;
                frame_tick <= 1'b1;
                disp_val   <= load ? value : pend_val;
                disp_dp    <= load ? dp_in : pend_dp;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a phase-arithmetic reference model queues the
// expected pin image per clock; a monitor pops and compares on the falling edge.
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int SCAN_N = 4;
  localparam int BLANK  = 2;
  localparam int SLOT   = 1 << SCAN_N;
  localparam int FRAME  = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        reset, enable, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out, frame_tick;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t sb[$];

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: position within the frame as a plain cycle count.
  bit          run = 0;
  int          p = 0;
  logic [15:0] pend_v = '0, disp_v = '0;
  logic [3:0]  pend_d = '0, disp_d = '0;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .SCAN_N(SCAN_N), .BLANK_CYC(BLANK),
    .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .an_out(an_out), .seg_out(seg_out),
    .dp_out(dp_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    exp_t e;
    int   d;
    bit   lit, dark;
    e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0;
    if (reset) begin
      run = 0; p = 0; pend_v = '0; pend_d = '0; disp_v = '0; disp_d = '0;
    end else begin
      lit = enable && run && ((p % SLOT) >= BLANK);
      d   = p / SLOT;
      if (lit) begin
        dark = blank_lz && (d > 0) && ((disp_v >> (4 * d)) == 16'h0);
        e.an = ~(4'(1) << d);
        if (!dark) begin
          e.seg = ~hex_tab[(disp_v >> (4 * d)) & 16'hF];
          e.dp  = ~disp_d[d];
        end
      end
      if (load) begin
        pend_v = value;
        pend_d = dp_in;
      end
      if (!enable) begin
        run = 0; p = 0;
      end else if (!run) begin
        run = 1; p = 0;
        disp_v = pend_v; disp_d = pend_d; e.ft = 1'b1;
      end else begin
        p = (p + 1) % FRAME;
        if (p == 0) begin
          disp_v = pend_v; disp_d = pend_d; e.ft = 1'b1;
        end
      end
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (an_out !== e.an || seg_out !== e.seg || dp_out !== e.dp || frame_tick !== e.ft) begin
        miscompares++;
        $display("FAIL pins t=%0t an/seg/dp/ft got %h/%h/%b/%b required %h/%h/%b/%b",
                 $time, an_out, seg_out, dp_out, frame_tick, e.an, e.seg, e.dp, e.ft);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait until the model says the next rising edge lands at frame position `target`.
  task automatic wait_phase(input int target, input string tag);
    int i;
    for (i = 0; i < 4 * FRAME && !(run && enable && p == target - 1); i++) @(negedge clk);
    if (!(run && enable && p == target - 1)) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout got phase %0d required %0d", tag, p, target - 1);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; load = 1'b0; blank_lz = 1'b0; value = '0; dp_in = '0;
    cycles(5);

    reset = 1'b0; enable = 1'b0;
    pulse_load(16'h12AF, 4'b0101);
    enable = 1'b1;
    cycles(3 * FRAME + 10);

    pulse_load(16'h0000, 4'b0000);
    wait_phase(FRAME, "frame0");
    cycles(20);
    pulse_load(16'h1234, 4'b1000);
    cycles(2 * FRAME);

    blank_lz = 1'b1;
    pulse_load(16'h0050, 4'b0000);
    cycles(2 * FRAME + 5);
    pulse_load(16'h0000, 4'b0000);
    cycles(2 * FRAME + 5);
    blank_lz = 1'b0;

    wait_phase(2 * SLOT + BLANK + 3, "digit2show");
    @(negedge clk);
    enable = 1'b0;
    cycles(4);
    enable = 1'b1;
    cycles(SLOT + 4);

    wait_phase(FRAME, "framestart");
    pulse_load(16'hBEEF, 4'b0011);
    cycles(FRAME + 4);

    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 599) == 0);
      enable = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      load   = ($urandom_range(0, 19) == 0);
      value  = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      dp_in  = 4'($urandom);
      @(negedge clk);
    end
    reset = 1'b0; load = 1'b0;
    cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
